// File: rtl/approx_adder_mse_monitor.sv
`default_nettype none
// ============================================================================
// Module  : approx_adder_mse_monitor
// Purpose : Error statistics (SSE, SAE, max |err|, count) of an approximate
//           adder over a run of N_SAMPLES. Option macro: BIAS_ACC_EN adds a
//           signed, saturating error-sum output 'bias'.
// Revision: 1.0 - initial release
// ============================================================================
module approx_adder_mse_monitor #(
  parameter int WIDTH     = 16,
  parameter int N_SAMPLES = 1024,
  parameter int ACC_W     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   IN1,
  input  logic [WIDTH-1:0]   IN2,
  input  logic [WIDTH:0]     APPROX,
  output logic [ACC_W-1:0]   sse,
  output logic [WIDTH+23:0]  sae,
  output logic [WIDTH:0]     max_err,
  output logic [31:0]        count,
  output logic               done
`ifdef BIAS_ACC_EN
  ,output logic signed [WIDTH+23:0] bias
`endif
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [31:0] c_LAST  = 32'(N_SAMPLES - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_drain_cnt;
  logic               r_s1_valid;
  logic [WIDTH+1:0]   r_s1_err;
  logic [ACC_W-1:0]   r_sse;
  logic [WIDTH+23:0]  r_sae;
  logic [WIDTH:0]     r_max;
  logic [31:0]        r_count;

  logic               w_accept;
  logic               w_last;
  logic               w_clear;
  logic [WIDTH:0]     w_exact;
  logic [WIDTH+1:0]   w_err;
  logic [WIDTH:0]     w_abs;
  logic [2*WIDTH+1:0] w_sq;
  logic [ACC_W:0]     w_sse_sum;
  logic [WIDTH+24:0]  w_sae_sum;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_count == c_LAST);
  assign w_clear  = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // APPROX and exact are both unsigned; one extra bit makes the difference signed.
  assign w_exact = {1'b0, IN1} + {1'b0, IN2};
  assign w_err   = {1'b0, APPROX} - {1'b0, w_exact};

  assign w_abs     = r_s1_err[WIDTH+1] ? (WIDTH+1)'(-r_s1_err) : r_s1_err[WIDTH:0];
  assign w_sq      = {{(WIDTH+1){1'b0}}, w_abs} * {{(WIDTH+1){1'b0}}, w_abs};
  assign w_sse_sum = {1'b0, r_sse} + (ACC_W+1)'(w_sq);
  assign w_sae_sum = {1'b0, r_sae} + (WIDTH+25)'(w_abs);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_RUN:   in_ready = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  // S1: error capture and sample count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= '0;
      r_count    <= '0;
    end else if (w_clear) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= '0;
      r_count    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_err <= w_err;
        r_count  <= r_count + 32'd1;
      end
    end
  end

  // S2: saturating accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sse <= '0;
      r_sae <= '0;
      r_max <= '0;
    end else if (w_clear) begin
      r_sse <= '0;
      r_sae <= '0;
      r_max <= '0;
    end else if (r_s1_valid) begin
      r_sse <= w_sse_sum[ACC_W] ? '1 : w_sse_sum[ACC_W-1:0];
      r_sae <= w_sae_sum[WIDTH+24] ? '1 : w_sae_sum[WIDTH+23:0];
      if (w_abs > r_max) r_max <= w_abs;
    end
  end

`ifdef BIAS_ACC_EN
  logic signed [WIDTH+23:0] r_bias;
  logic        [WIDTH+24:0] w_bias_sum;

  assign w_bias_sum = {r_bias[WIDTH+23], r_bias} + {{23{r_s1_err[WIDTH+1]}}, r_s1_err};

  // Overflow shows as disagreement between the two top bits of the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias <= '0;
    end else if (w_clear) begin
      r_bias <= '0;
    end else if (r_s1_valid) begin
      if (w_bias_sum[WIDTH+24] != w_bias_sum[WIDTH+23])
        r_bias <= {w_bias_sum[WIDTH+24], {(WIDTH+23){~w_bias_sum[WIDTH+24]}}};
      else
        r_bias <= w_bias_sum[WIDTH+23:0];
    end
  end

  assign bias = r_bias;
`endif

  assign sse     = r_sse;
  assign sae     = r_sae;
  assign max_err = r_max;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_mse_monitor.sv
`default_nettype none
// Directed bench for approx_adder_mse_monitor (N_SAMPLES=4) with a
// run-level scoreboard of expected statistics.
module tb_approx_adder_mse_monitor;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  IN1 = '0;
  logic [W-1:0]  IN2 = '0;
  logic [W:0]    APPROX = '0;
  logic [63:0]   sse;
  logic [W+23:0] sae;
  logic [W:0]    max_err;
  logic [31:0]   count;
  logic          done;
`ifdef BIAS_ACC_EN
  logic signed [W+23:0] bias;
`endif

  approx_adder_mse_monitor #(.WIDTH(W), .N_SAMPLES(N), .ACC_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .IN1(IN1), .IN2(IN2), .APPROX(APPROX),
    .sse(sse), .sae(sae), .max_err(max_err), .count(count), .done(done)
`ifdef BIAS_ACC_EN
    , .bias(bias)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sse;
    longint sae;
    longint mx;
    longint cnt;
    longint bias;
  } exp_t;

  exp_t   sb[$];
  longint m_sse, m_sae, m_max, m_cnt, m_bias;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_sse = 0; m_sae = 0; m_max = 0; m_cnt = 0; m_bias = 0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  // Offers one sample until it is accepted; rnd randomises in_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W:0] ap, input bit rnd);
    bit taken = 0;
    int guard = 0;
    IN1 = a; IN2 = b; APPROX = ap;
    while (!taken) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) begin
        longint e = longint'(ap) - (longint'(a) + longint'(b));
        longint ae = (e < 0) ? -e : e;
        m_sse += e * e;
        m_sae += ae;
        if (ae > m_max) m_max = ae;
        m_cnt++;
        m_bias += e;
        taken = 1;
      end
      tick();
      in_valid = 1'b0;
      guard++;
      if (!taken && guard > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        taken = 1;
      end
    end
    if (m_cnt == N) begin
      exp_t x;
      x.sse = m_sse; x.sae = m_sae; x.mx = m_max; x.cnt = m_cnt; x.bias = m_bias;
      sb.push_back(x);
    end
  endtask

  task automatic compare_stats(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_sse"}, sse, 64'(x.sse));
      chk({tag, "_sae"}, 64'(sae), 64'(x.sae));
      chk({tag, "_max"}, 64'(max_err), 64'(x.mx));
      chk({tag, "_count"}, 64'(count), 64'(x.cnt));
`ifdef BIAS_ACC_EN
      chk({tag, "_bias"}, 64'(longint'(bias)), 64'(x.bias));
`endif
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    compare_stats(tag);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_sse", sse, 64'd0);
    chk("rst_sae", 64'(sae), 64'd0);
    chk("rst_max", 64'(max_err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 64'(in_ready), 64'd0);

    // Run 1: all-zero samples
    start_run();
    chk("run1_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < N; i++) send('0, '0, '0, 1'b0);
    wait_done("run1");

    // Run 2: err = -1 once, then zeros
    start_run();
    chk("run2_cleared", 64'(count), 64'd0);
    send(16'h0001, 16'h0001, 17'h00001, 1'b0);
    for (int i = 1; i < N; i++) send('0, '0, '0, 1'b0);
    wait_done("run2");

    // Run 3: err = -511 and +1 mixed
    start_run();
    send(16'h0000, 16'h01FF, 17'h00000, 1'b0);
    send(16'h0000, 16'h03FF, 17'h00400, 1'b0);
    send('0, '0, '0, 1'b0);
    send('0, '0, '0, 1'b0);
    wait_done("run3");

    // Run 4: random valid, extreme and random operands, start ignored in RUN
    start_run();
    send(16'hFFFF, 16'hFFFF, 17'h00000, 1'b1);
    send(16'h0000, 16'h0000, 17'h1FFFF, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run4_start_ignored", 64'(count), 64'd2);
    chk("run4_still_ready", 64'(in_ready), 64'd1);
    send(16'($urandom), 16'($urandom), 17'($urandom), 1'b1);
    send(16'($urandom), 16'($urandom), 17'($urandom), 1'b1);
    chk("run4_ready_drop", 64'(in_ready), 64'd0);
    chk("run4_done_early0", 64'(done), 64'd0);
    tick();
    chk("run4_done_early1", 64'(done), 64'd0);
    tick();
    chk("run4_done_on_time", 64'(done), 64'd1);
    compare_stats("run4");

    // Run 5: asynchronous reset after two accepts
    start_run();
    send(16'h0000, 16'h01FF, 17'h00000, 1'b0);
    send(16'h1234, 16'h0101, 17'h00000, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sse", sse, 64'd0);
    chk("arst_sae", 64'(sae), 64'd0);
    chk("arst_max", 64'(max_err), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_run();
    chk("fresh_count", 64'(count), 64'd0);
    chk("fresh_ready", 64'(in_ready), 64'd1);
    send(16'h8000, 16'h8000, 17'h0FFFF, 1'b0);
    for (int i = 1; i < N; i++) send(16'h00FF, 16'h0001, 17'h00100, 1'b0);
    wait_done("run5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
